full_adder: RTL and testbench

- Binary full adder: adds operands a and b plus a carry-in cin, and produces sum and carry-out.
- The default configuration is a 1-bit cell. It is used as a leaf arithmetic primitive and as the building block of wider ripple adders.
- It has two output sets. The combinational outputs have zero latency. The registered copies are for pipelined users.

---
 rtl/full_adder_pkg.sv | 11 +
 rtl/fa_bit.sv | 18 +
 rtl/full_adder.sv | 58 +++++
 tb/tb_full_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// full_adder_pkg -- shared constants for the ripple-carry adder slice.
// Rev 1.0
`default_nettype none

package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

endpackage : full_adder_pkg

`default_nettype wire

// File: rtl/fa_bit.sv
// fa_bit -- single-bit combinational full-adder cell.
// Rev 1.0
`default_nettype none

module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule : fa_bit

`default_nettype wire

// File: rtl/full_adder.sv
// full_adder -- WIDTH-bit ripple-carry adder with a combinational result and a registered copy.
// Rev 1.0
`default_nettype none

module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("full_adder: WIDTH must be within 1..MAX_WIDTH");
    end
  endgenerate

  // chain[i] is the carry into bit i; chain[WIDTH] is the carry-out.
  logic [WIDTH:0] chain;

  assign chain[0] = cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      fa_bit u_fa_bit (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (chain[i]),
        .sum  (sum[i]),
        .carry(chain[i+1])
      );
    end
  endgenerate

  assign carry = chain[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

endmodule : full_adder

`default_nettype wire

// File: tb/tb_full_adder.sv
// tb_full_adder -- scoreboard bench for full_adder at WIDTH=1 and WIDTH=8.
// Rev 1.0
`default_nettype none

module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       sum1, carry1, sum1_q, carry1_q;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic [7:0] sum8, sum8_q;
  logic       carry8, carry8_q;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .carry(carry1), .sum_q(sum1_q), .carry_q(carry1_q)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .carry(carry8), .sum_q(sum8_q), .carry_q(carry8_q)
  );

  // sel: 0 = w1 comb, 1 = w1 reg, 2 = w8 comb, 3 = w8 reg
  typedef struct {
    string      name;
    int         sel;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [8:0] observed(int sel);
    case (sel)
      0:       return {7'b0, carry1, sum1};
      1:       return {7'b0, carry1_q, sum1_q};
      2:       return {carry8, sum8};
      default: return {carry8_q, sum8_q};
    endcase
  endfunction

  // Monitor: drains every pending expectation whenever the driver says outputs are settled.
  initial begin
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        exp_t e;
        logic [8:0] act;
        e   = sb.pop_front();
        act = observed(e.sel);
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got {carry,sum}=%h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // Reference model: plain unsigned addition at full precision.
  function automatic logic [8:0] ref_add(logic [7:0] x, logic [7:0] y, logic c, int w);
    int unsigned total;
    total = int'(x) + int'(y) + int'(c);
    if (w == 1) return 9'(total & 32'h3);
    return 9'(total & 32'h1FF);
  endfunction

  task automatic expect_val(string name, int sel, logic [8:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic settle_and_sample();
    #2;
    -> sample_ev;
    #1;
  endtask

  task automatic pulse_clk();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  initial begin
    logic [8:0] exp8, prev8;
    logic [2:0] v;

    // Reset state with clk idle.
    #3;
    expect_val("reset_w1_reg", 1, 9'h000);
    expect_val("reset_w8_reg", 3, 9'h000);
    settle_and_sample();

    // WIDTH=1 exhaustive, clk idle, reset held.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin1} = v;
      #10;
      expect_val($sformatf("w1_comb_%0d", i), 0, ref_add({7'b0, v[2]}, {7'b0, v[1]}, v[0], 1));
      expect_val($sformatf("w1_reg_held_%0d", i), 1, 9'h000);
      settle_and_sample();
    end

    // Registered path: value must only appear at the edge.
    rst = 1'b0;
    {a1, b1, cin1} = 3'b110;
    expect_val("w1_reg_before_edge", 1, 9'h000);
    settle_and_sample();
    pulse_clk();
    expect_val("w1_reg_after_edge", 1, 9'h002);
    settle_and_sample();

    // Async reset between edges; combinational path unaffected.
    {a1, b1, cin1} = 3'b111;
    pulse_clk();
    expect_val("w1_reg_loaded", 1, 9'h003);
    settle_and_sample();
    #2 rst = 1'b1;
    #1;
    expect_val("w1_reg_async_clear", 1, 9'h000);
    expect_val("w1_comb_in_reset", 0, 9'h003);
    settle_and_sample();

    // Reset release.
    {a1, b1, cin1} = 3'b010;
    #2 rst = 1'b0;
    expect_val("w1_reg_after_release", 1, 9'h000);
    settle_and_sample();
    pulse_clk();
    expect_val("w1_reg_first_capture", 1, 9'h001);
    settle_and_sample();

    // WIDTH=8 directed boundaries.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    expect_val("w8_ripple", 2, 9'h100);
    settle_and_sample();
    a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b0;
    expect_val("w8_alt_bits", 2, 9'h0FF);
    settle_and_sample();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    expect_val("w8_all_ones", 2, 9'h1FF);
    settle_and_sample();
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    expect_val("w8_all_zero", 2, 9'h000);
    settle_and_sample();

    // WIDTH=8 random; registered copy trails by one cycle.
    prev8 = '0;
    for (int i = 0; i < 1000; i++) begin
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      exp8 = ref_add(a8, b8, cin8, 8);
      expect_val("w8_rand_comb", 2, exp8);
      if (i > 0) expect_val("w8_rand_reg", 3, prev8);
      settle_and_sample();
      pulse_clk();
      prev8 = exp8;
    end
    expect_val("w8_rand_reg_last", 3, prev8);
    settle_and_sample();

    #5;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the sequence is short and self-timed.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_full_adder

`default_nettype wire
